// File: rtl/count.sv
// count -- free-running WIDTH-bit up/down counter.
//
// Ports:
//   Clk      in   1      single clock, rising edge active
//   reset    in   1      asynchronous, active-high; forces Count to 0
//   UpOrDown in   1      direction, sampled at the rising edge: 1 = up, 0 = down
//   Count    out  WIDTH  current value, taken directly from the state register
//
// The counter steps on every edge while reset is low. There is no enable and no
// carry or borrow output. Wrap-around is the natural modulo 2^WIDTH behaviour of
// the register, so 15 -> 0 counting up and 0 -> 15 counting down need no extra
// logic and never add a stall cycle.
module count #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             UpOrDown,
  output logic [WIDTH-1:0] Count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt;

  // The next value depends only on the register and UpOrDown. Nothing from this
  // path reaches Count between edges, so a change on UpOrDown cannot glitch the
  // output.
  always_comb begin
    nxt = Count;
    if (UpOrDown) nxt = Count + ONE;
    else          nxt = Count - ONE;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) Count <= '0;
    else       Count <= nxt;
  end

endmodule

// File: tb/tb_count.sv
// Directed bench for count (WIDTH = 4). Inputs change away from the rising edge,
// and outputs are sampled 1 ns after it.
module tb_count;
  logic       Clk;
  logic       reset;
  logic       UpOrDown;
  logic [3:0] Count;

  int errs   = 0;
  int checks = 0;

  count #(.WIDTH(4)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .UpOrDown (UpOrDown),
    .Count    (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    reset    = 1'b0;
    UpOrDown = 1'b0;
    #2 reset = 1'b1;
    #1 chk("reset_async", Count, 4'd0);
    step(); chk("reset_hold0", Count, 4'd0);
    UpOrDown = 1'b1;
    step(); chk("reset_hold1", Count, 4'd0);

    // Release with down: 15,14,...,1,0.
    UpOrDown = 1'b0;
    reset    = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      e = 4'(16 - i);
      chk($sformatf("down_%0d", i), Count, e);
    end

    // Count up from 0: 1,2,...,15,0.
    UpOrDown = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      e = 4'(i);
      chk($sformatf("up_%0d", i), Count, e);
    end

    // Up to 7, then reverse direction: 6, 5, then up again to 6.
    for (int i = 0; i < 7; i++) step();
    chk("reach7", Count, 4'd7);
    UpOrDown = 1'b0;
    step(); chk("rev_6", Count, 4'd6);
    step(); chk("rev_5", Count, 4'd5);
    UpOrDown = 1'b1;
    step(); chk("fwd_6", Count, 4'd6);

    // Up to 9, then assert reset midway between edges.
    step(); step(); step();
    chk("reach9", Count, 4'd9);
    #4 reset = 1'b1;
    #1 chk("reset_mid", Count, 4'd0);
    for (int i = 0; i < 10; i++) begin
      UpOrDown = ~UpOrDown;
      step();
      chk($sformatf("rst_hold_%0d", i), Count, 4'd0);
    end

    // Release with down: 15 then 14.
    UpOrDown = 1'b0;
    #2 reset = 1'b0;
    step(); chk("rel_dn_1", Count, 4'd15);
    step(); chk("rel_dn_2", Count, 4'd14);

    // Several toggles between two edges, ending at up: one +1 step, no glitch.
    for (int i = 0; i < 5; i++) begin
      UpOrDown = ~UpOrDown;
      #1 chk($sformatf("noglitch_%0d", i), Count, 4'd14);
    end
    UpOrDown = 1'b1;
    #1 chk("noglitch_end", Count, 4'd14);
    step(); chk("toggle_step", Count, 4'd15);
    step(); chk("wrap_up", Count, 4'd0);

    // Release with up: the first edge gives 1.
    reset = 1'b1;
    #1 chk("reset_again", Count, 4'd0);
    reset = 1'b0;
    step(); chk("rel_up_1", Count, 4'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
